// File: rtl/config_usb_pkg.sv
// Constants and state encoding shared by the configuration stream transmitter
// and receiver, so both ends agree on framing bytes.
package config_usb_pkg;

    localparam logic [7:0]  SYNC_HDR_B0     = 8'h00;
    localparam logic [7:0]  SYNC_HDR_B1     = 8'hAA;
    localparam logic [7:0]  SYNC_HDR_B2     = 8'hFF;

    localparam int unsigned DESYNC_FLAG_POS = 20;
    localparam logic [31:0] DESYNC_FRAME    = 32'h1 << DESYNC_FLAG_POS;
    localparam logic [31:0] DONE_FRAME      = 32'hFAB0_FABF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WORD     = 3'd3,
        ST_DESYNC   = 3'd4,
        ST_WAIT_ACK = 3'd5
    } tx_state_e;

    function automatic logic [31:0] sync_header(input logic [7:0] mode);
        return {SYNC_HDR_B0, SYNC_HDR_B1, SYNC_HDR_B2, mode};
    endfunction

    // Byte 0 is the most significant byte: words travel MSB-first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/config_ack_matcher.sv
// Watches the return byte stream for the DONE word while enabled and
// times out if it does not arrive within ACK_TIMEOUT cycles.
module config_ack_matcher
    import config_usb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1000000
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic [7:0] ack_data_i,
    input  logic       ack_valid_i,
    output logic       match_o,
    output logic       timeout_o
);

    localparam int unsigned    CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [31:0]      shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_shift_msb;

    // Only the low three bytes take part in the sliding-window compare.
    assign unused_shift_msb = ^shift_q[31:24];

    always_comb begin
        shift_d = shift_q;
        if (clear_i) begin
            shift_d = '0;
        end else if (enable_i && ack_valid_i) begin
            shift_d = {shift_q[23:0], ack_data_i};
        end
    end

    // Held at zero outside the wait window, so every wait starts from 0.
    always_comb begin
        cnt_d = '0;
        if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign match_o   = enable_i && ack_valid_i && ({shift_q[23:0], ack_data_i} == DONE_FRAME);
    assign timeout_o = enable_i && (cnt_q == CNT_LAST) && !match_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/config_stream_tx.sv
// Serialises 32-bit configuration words into a framed byte stream
// (sync header, words MSB-first, desync word) and waits for DONE.
module config_stream_tx
    import config_usb_pkg::*;
#(
    parameter int unsigned SYNC_MODE   = 1,
    parameter int unsigned ACK_TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    input  logic        word_last_i,
    output logic        word_ready_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    input  logic [7:0]  ack_data_i,
    input  logic        ack_valid_i,
    output logic        ack_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o
);

    localparam logic [31:0] HDR_WORD = sync_header(8'(SYNC_MODE));

    tx_state_e   state_q, state_d;
    logic [1:0]  idx_q, idx_d, idx_inc;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic        accept;
    logic        ack_clear;
    logic        ack_enable;
    logic        ack_match;
    logic        ack_timeout;

    assign accept  = out_valid_q && out_ready_i;
    assign idx_inc = idx_q + 2'd1;

    // The next byte is loaded on the accepting edge, so there is no bubble
    // inside a 4-byte group; only LOAD (waiting for a word) drops valid.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_d      = word_q;
        last_d      = last_q;
        ack_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (word_valid_i) begin
                    state_d     = ST_HDR;
                    idx_d       = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = word_byte(HDR_WORD, 2'd0);
                    ack_clear   = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    idx_d = idx_inc;
                    if (idx_q == 2'd3) begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                    end else begin
                        out_data_d = word_byte(HDR_WORD, idx_inc);
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid_i) begin
                    state_d     = ST_WORD;
                    word_d      = word_i;
                    last_d      = word_last_i;
                    idx_d       = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = word_byte(word_i, 2'd0);
                end
            end
            ST_WORD: begin
                if (accept) begin
                    idx_d = idx_inc;
                    if (idx_q != 2'd3) begin
                        out_data_d = word_byte(word_q, idx_inc);
                    end else if (last_q) begin
                        state_d    = ST_DESYNC;
                        out_data_d = word_byte(DESYNC_FRAME, 2'd0);
                    end else begin
                        state_d     = ST_LOAD;
                        out_valid_d = 1'b0;
                    end
                end
            end
            ST_DESYNC: begin
                if (accept) begin
                    idx_d = idx_inc;
                    if (idx_q == 2'd3) begin
                        state_d     = ST_WAIT_ACK;
                        out_valid_d = 1'b0;
                    end else begin
                        out_data_d = word_byte(DESYNC_FRAME, idx_inc);
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (ack_match || ack_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
            last_q      <= last_d;
        end
    end

    assign ack_enable = (state_q == ST_WAIT_ACK);

    config_ack_matcher #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_matcher (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (ack_enable),
        .clear_i     (ack_clear),
        .ack_data_i  (ack_data_i),
        .ack_valid_i (ack_valid_i),
        .match_o     (ack_match),
        .timeout_o   (ack_timeout)
    );

    assign word_ready_o = (state_q == ST_LOAD);
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign ack_ready_o  = 1'b1;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = ack_match;
    assign timeout_o    = ack_timeout;

endmodule

// File: tb/tb_config_stream_tx.sv
// Directed bench for config_stream_tx: framing, handshake stalls, ack
// matching, ack timeout and asynchronous reset mid-frame.
module tb_config_stream_tx;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [31:0] word_i = '0;
    logic        word_valid_i = 1'b0;
    logic        word_last_i = 1'b0;
    logic        word_ready_o;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  ack_data_i = '0;
    logic        ack_valid_i = 1'b0;
    logic        ack_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] words [0:2];

    always #5 clk_i = ~clk_i;

    config_stream_tx #(
        .SYNC_MODE   (1),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_last_i  (word_last_i),
        .word_ready_o (word_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .ack_data_i   (ack_data_i),
        .ack_valid_i  (ack_valid_i),
        .ack_ready_o  (ack_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},  out_valid_o,  0);
        check({tag, "_data"},   out_data_o,   0);
        check({tag, "_wready"}, word_ready_o, 0);
        check({tag, "_busy"},   busy_o,       0);
        check({tag, "_done"},   done_o,       0);
        check({tag, "_tmo"},    timeout_o,    0);
    endtask

    // Starts at a negedge in IDLE; returns at the negedge where the final
    // desync byte is presented with out_ready_i high.
    task automatic run_frame(input int nwords, input bit rand_ready, input bit hdr_ack);
        logic [7:0] exp_bytes[$];
        logic [31:0] hdr_ack_bytes;
        logic [7:0] prev_data;
        int exp_idx = 0;
        int wr_cnt = 0;
        int widx = 0;
        int cyc = 0;
        int ack_k = 0;
        int stab_err = 0;
        int flag_seen = 0;
        bit pend = 0;
        bit prev_stall = 0;
        exp_bytes = '{8'h00, 8'hAA, 8'hFF, 8'h01};
        for (int w = 0; w < nwords; w++) begin
            exp_bytes.push_back(words[w][31:24]);
            exp_bytes.push_back(words[w][23:16]);
            exp_bytes.push_back(words[w][15:8]);
            exp_bytes.push_back(words[w][7:0]);
        end
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h10);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        hdr_ack_bytes = 32'hFAB0_FABF;
        prev_data = '0;
        word_i       = words[0];
        word_last_i  = (nwords == 1);
        word_valid_i = 1'b1;
        out_ready_i  = 1'b1;
        while (exp_idx < exp_bytes.size() && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) check("hdr_latency", {out_valid_o, out_data_o}, {1'b1, 8'h00});
            if (pend) begin
                pend = 0;
                widx++;
                if (widx < nwords) begin
                    word_i      = words[widx];
                    word_last_i = (widx == nwords - 1);
                end else begin
                    word_valid_i = 1'b0;
                end
            end
            if (word_ready_o) wr_cnt++;
            if (word_ready_o && word_valid_i) pend = 1;
            if (done_o || timeout_o) flag_seen++;
            if (prev_stall && !(out_valid_o && out_data_o == prev_data)) stab_err++;
            if (hdr_ack && ack_k < 4) begin
                ack_valid_i = 1'b1;
                ack_data_i  = hdr_ack_bytes[31 - 8*ack_k -: 8];
                ack_k++;
            end else begin
                ack_valid_i = 1'b0;
            end
            out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid_o && out_ready_i) begin
                check($sformatf("byte%0d", exp_idx), out_data_o, exp_bytes[exp_idx]);
                exp_idx++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid_o;
                prev_data  = out_data_o;
            end
        end
        check("frame_complete", exp_idx, exp_bytes.size());
        check("word_ready_cycles", wr_cnt, nwords);
        check("stall_stability_errs", stab_err, 0);
        check("no_flag_in_frame", flag_seen, 0);
        out_ready_i = 1'b1;
    endtask

    // Called right after run_frame; first negedge lands in WAIT_ACK.
    task automatic send_ack(input int n, input logic [39:0] bytes);
        @(negedge clk_i);
        for (int k = 0; k < n; k++) begin
            ack_valid_i = 1'b1;
            ack_data_i  = bytes[8*(n-1-k) +: 8];
            #1;
            check($sformatf("ack_done_k%0d", k), done_o, (k == n - 1));
            check($sformatf("ack_tmo_k%0d", k),  timeout_o, 0);
            @(negedge clk_i);
        end
        ack_valid_i = 1'b0;
        check("post_ack_busy", busy_o, 0);
        check("post_ack_done", done_o, 0);
        check("post_ack_tmo",  timeout_o, 0);
    endtask

    initial begin
        int early_tmo;
        bit hit;
        bit pend;
        int nb;

        // Reset state
        @(negedge clk_i);
        check_idle_outputs("reset");
        check("reset_ack_ready", ack_ready_o, 1);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Single word, no ack: full frame then timeout after 16 WAIT_ACK cycles
        words[0] = 32'h1234_5678;
        run_frame(1, 0, 0);
        early_tmo = 0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk_i);
            if (k < 15 && (timeout_o || done_o || !busy_o)) early_tmo++;
            if (k == 15) begin
                check("tmo_pulse", timeout_o, 1);
                check("tmo_done",  done_o,    0);
                check("tmo_busy",  busy_o,    1);
            end
            if (k == 16) begin
                check("tmo_idle_busy", busy_o,    0);
                check("tmo_idle_pulse", timeout_o, 0);
            end
        end
        check("tmo_early_flags", early_tmo, 0);

        // Same word with DONE acknowledge
        run_frame(1, 0, 0);
        send_ack(4, 40'h00_FAB0_FABF);

        // Three words with random back-pressure
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h0000_00FF;
        words[2] = 32'hA5C3_3C5A;
        run_frame(3, 1, 0);
        send_ack(4, 40'h00_FAB0_FABF);

        // DONE bytes during the header are ignored; sliding-window match later
        words[0] = 32'h0102_0304;
        run_frame(1, 0, 1);
        send_ack(5, 40'hFA_FAB0_FABF);

        // Asynchronous reset while WORD byte 2 is presented
        word_i       = 32'hCAFE_F00D;
        word_last_i  = 1'b1;
        word_valid_i = 1'b1;
        out_ready_i  = 1'b1;
        hit  = 0;
        pend = 0;
        nb   = 0;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk_i);
            if (pend) begin
                word_valid_i = 1'b0;
                pend = 0;
            end
            if (word_ready_o && word_valid_i) pend = 1;
            if (out_valid_o) begin
                if (nb == 6) begin
                    check("mid_word_byte2", out_data_o, 8'hF0);
                    hit = 1;
                end
                nb++;
            end
        end
        check("mid_word_reached", hit, 1);
        word_valid_i = 1'b0;
        #1 reset_n_i = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk_i);
        check_idle_outputs("held_rst");
        reset_n_i = 1'b1;
        words[0] = 32'h0BAD_F00D;
        run_frame(1, 0, 0);
        send_ack(4, 40'h00_FAB0_FABF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
